// File: rtl/conv.sv
// conv: first CNN convolution layer.
// Raster-scanned unsigned 8-bit pixels in, NUM_FEATURE_MAPS signed 16-bit
// results out, one per valid K x K window (stride 1, no padding).
// Each map uses a single weight on every tap: +(m+1) for even m, -(m+1) for odd m.
// Optional build macro CONV_RELU_EN: clamp negative results to 0 after saturation.
module conv #(
  parameter int IMG_W            = 32,
  parameter int IMG_H            = 32,
  parameter int K                = 5,
  parameter int NUM_FEATURE_MAPS = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_feature_valid,
  input  logic [7:0]         i_feature,
  output logic               o_ready_feature,
  output logic               o_feature_valid,
  output logic signed [15:0] o_features [0:NUM_FEATURE_MAPS-1]
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  // Window sum of K*K unsigned pixels.
  localparam int SW    = 8 + $clog2(K * K);
  // Signed accumulator: sum times largest weight magnitude, never below 20 bits.
  localparam int ACC_NEED = SW + $clog2(NUM_FEATURE_MAPS + 1) + 1;
  localparam int ACC_W = (ACC_NEED > 20) ? ACC_NEED : 20;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  logic          accept;
  logic [7:0]    col_pix [K];        // new window column, index 0 = oldest row
  logic [7:0]    win [K][K];         // [row][col], col K-1 is the newest
  logic [SW-1:0] win_sum;
  logic          win_valid_reg;
  logic          acc_valid_reg;
  logic signed [ACC_W-1:0] prod    [NUM_FEATURE_MAPS];
  logic signed [ACC_W-1:0] acc_reg [NUM_FEATURE_MAPS];
  logic signed [15:0]      sat_val [NUM_FEATURE_MAPS];

  assign accept           = i_feature_valid && o_ready_feature;
  assign col_pix[K-1]     = i_feature;

  // Next raster position; only an accepted pixel moves it.
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
      end else begin
        col_next = col_reg + CW'(1);
      end
    end
  end

  // Position counters and the always-ready handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      col_reg         <= '0;
      row_reg         <= '0;
      o_ready_feature <= 1'b0;
    end else begin
      col_reg         <= col_next;
      row_reg         <= row_next;
      o_ready_feature <= 1'b1;
    end
  end

  // Line buffers: line gi holds the row gi+1 above the current one. The read
  // is registered at the column the next accepted pixel will land on, so the
  // data is ready on acceptance; the write address (current column) differs.
  genvar gi;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_line
      logic [7:0] mem [IMG_W];
      logic [7:0] rd_reg;

      // Push this column down one line and prefetch the next column.
      always_ff @(posedge i_clk) begin
        if (accept) begin
          mem[col_reg] <= col_pix[K-1-gi];
        end
        rd_reg <= mem[col_next];
      end

      assign col_pix[K-2-gi] = rd_reg;
    end
  endgenerate

  // Window shifts left one column per accepted pixel.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= col_pix[r];
      end
    end
  end

  // All taps of a map share one weight, so one pixel sum serves every map.
  always_comb begin
    win_sum = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_sum = win_sum + SW'(win[r][c]);
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_FEATURE_MAPS; gi++) begin : g_map
      localparam logic signed [ACC_W-1:0] WT =
        (gi % 2 == 0) ? ACC_W'(gi + 1) : -ACC_W'(gi + 1);
      logic signed [15:0] sat_g;

      assign prod[gi] = $signed({{(ACC_W-SW){1'b0}}, win_sum}) * WT;

      // Clamp to signed 16 bits, optionally rectify.
      always_comb begin
        if (acc_reg[gi] > SAT_MAX) begin
          sat_g = 16'sh7fff;
        end else if (acc_reg[gi] < SAT_MIN) begin
          sat_g = 16'sh8000;
        end else begin
          sat_g = $signed(acc_reg[gi][15:0]);
        end
`ifdef CONV_RELU_EN
        if (sat_g < 16'sd0) begin
          sat_g = 16'sd0;
        end
`endif
      end

      assign sat_val[gi] = sat_g;
    end
  endgenerate

  // Two-stage result pipeline; it advances every cycle so each window pulses once.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      win_valid_reg   <= 1'b0;
      acc_valid_reg   <= 1'b0;
      o_feature_valid <= 1'b0;
      for (int m = 0; m < NUM_FEATURE_MAPS; m++) begin
        o_features[m] <= '0;
      end
    end else begin
      win_valid_reg   <= accept && (row_reg >= ROW_WIN) && (col_reg >= COL_WIN);
      acc_valid_reg   <= win_valid_reg;
      o_feature_valid <= acc_valid_reg;
      for (int m = 0; m < NUM_FEATURE_MAPS; m++) begin
        if (acc_valid_reg) begin
          o_features[m] <= sat_val[m];
        end
      end
    end
  end

  // Stage 1 product register (data only, no reset needed).
  always_ff @(posedge i_clk) begin
    for (int m = 0; m < NUM_FEATURE_MAPS; m++) begin
      acc_reg[m] <= prod[m];
    end
  end

endmodule

// File: tb/tb_conv.sv
// tb_conv: randomized self-checking bench for conv against a frame-level model.
module tb_conv;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int K     = 5;
  localparam int NFM   = 6;
  localparam int NWIN  = (IMG_W - K + 1) * (IMG_H - K + 1);

  logic               i_clk;
  logic               i_rst;
  logic               i_feature_valid;
  logic [7:0]         i_feature;
  logic               o_ready_feature;
  logic               o_feature_valid;
  logic signed [15:0] o_features [0:NFM-1];

  conv #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_FEATURE_MAPS(NFM)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_feature_valid (i_feature_valid),
    .i_feature       (i_feature),
    .o_ready_feature (o_ready_feature),
    .o_feature_valid (o_feature_valid),
    .o_features      (o_features)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int due;
    int v [NFM];
  } exp_t;

  exp_t mq [$];
  int   img [IMG_H][IMG_W];
  int   m_row, m_col;
  bit   m_ready;
  bit   exp_valid, exp_ready;
  int   exp_feat [NFM];

  function automatic int weight(input int m);
    return (m % 2 == 0) ? (m + 1) : -(m + 1);
  endfunction

  function automatic int post(input int x);
    int y;
    y = x;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
`ifdef CONV_RELU_EN
    if (y < 0) y = 0;
`endif
    return y;
  endfunction

  // Drive one clock of stimulus, advance the model, sample #1 after the edge.
  task automatic step(input logic rst, input logic v, input logic [7:0] p);
    exp_t e;
    int   s;
    i_rst = rst;
    i_feature_valid = v;
    i_feature = p;
    @(posedge i_clk);
    cyc++;
    if (!rst) begin
      mq.delete();
      m_row = 0;
      m_col = 0;
      m_ready = 1'b0;
      foreach (exp_feat[m]) exp_feat[m] = 0;
    end else begin
      if (v && m_ready) begin
        img[m_row][m_col] = int'(p);
        if (m_row >= K - 1 && m_col >= K - 1) begin
          s = 0;
          for (int dr = 0; dr < K; dr++)
            for (int dc = 0; dc < K; dc++)
              s += img[m_row-dr][m_col-dc];
          e.due = cyc + 2;
          for (int m = 0; m < NFM; m++) e.v[m] = post(s * weight(m));
          mq.push_back(e);
        end
        m_col++;
        if (m_col == IMG_W) begin
          m_col = 0;
          m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end
      end
      m_ready = 1'b1;
    end
    exp_ready = rst;
    exp_valid = 1'b0;
    if (rst && mq.size() > 0 && mq[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_feat = mq[0].v;
      void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    bit bad;
    for (int i = 0; i < 6; i++) begin
      step((i < 3) ? 1'b0 : 1'b1, 1'b0, 8'd0);
      if (o_ready_feature !== exp_ready || o_feature_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL reset_ctrl cyc=%0d ready=%b valid=%b, want ready=%b valid=%b",
                 cyc, o_ready_feature, o_feature_valid, exp_ready, exp_valid);
      end
      vectors++;
      bad = 0;
      for (int m = 0; m < NFM; m++) if (o_features[m] !== 16'sd0) bad = 1;
      if (bad) begin
        miscompares++;
        $display("FAIL reset_data cyc=%0d got %0d,%0d,%0d,%0d,%0d,%0d want all 0", cyc,
                 o_features[0], o_features[1], o_features[2], o_features[3], o_features[4], o_features[5]);
      end
      vectors++;
    end
    $display("test_reset: done at cycle %0d", cyc);
  endtask

  task automatic test_const_frames();
    int  c40 [NFM];
    int  pulses [2];
    int  t132;
    bit  first_seen;
    bit  bad;
    c40 = '{1000, -2000, 3000, -4000, 5000, -6000};
    pulses = '{0, 0};
    first_seen = 0;
    t132 = 0;
    for (int idx = 0; idx < 2 * IMG_W * IMG_H + 3; idx++) begin
      if (idx < 2 * IMG_W * IMG_H) step(1'b1, 1'b1, 8'd40);
      else step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      if (idx == (K - 1) * IMG_W + (K - 1)) t132 = cyc;
      if (o_ready_feature !== exp_ready || o_feature_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL const_ctrl cyc=%0d ready=%b valid=%b, want ready=%b valid=%b",
                 cyc, o_ready_feature, o_feature_valid, exp_ready, exp_valid);
      end
      vectors++;
      if (o_feature_valid === 1'b1) begin
        pulses[(idx < IMG_W * IMG_H + 2) ? 0 : 1]++;
        if (!first_seen) begin
          first_seen = 1;
          if (cyc !== t132 + 2) begin
            miscompares++;
            $display("FAIL const_latency first pulse at cycle %0d, want %0d", cyc, t132 + 2);
          end
          vectors++;
        end
        bad = 0;
        for (int m = 0; m < NFM; m++) if (o_features[m] !== c40[m]) bad = 1;
        if (bad) begin
          miscompares++;
          $display("FAIL const_data cyc=%0d got %0d,%0d,%0d,%0d,%0d,%0d want 1000,-2000,3000,-4000,5000,-6000",
                   cyc, o_features[0], o_features[1], o_features[2], o_features[3], o_features[4], o_features[5]);
        end
        vectors++;
      end
    end
    if (!first_seen) begin
      miscompares++;
      $display("FAIL const_latency no pulse seen, want one at cycle %0d", t132 + 2);
    end
    vectors++;
    for (int f = 0; f < 2; f++) begin
      if (pulses[f] !== NWIN) begin
        miscompares++;
        $display("FAIL const_count frame %0d got %0d pulses want %0d", f, pulses[f], NWIN);
      end
      vectors++;
    end
    $display("test_const_frames: pulses %0d/%0d", pulses[0], pulses[1]);
  endtask

  task automatic test_saturation();
    int c255 [NFM];
    int pulses;
    bit first_seen, bad;
`ifdef CONV_RELU_EN
    c255 = '{6375, 0, 19125, 0, 31875, 0};
`else
    c255 = '{6375, -12750, 19125, -25500, 31875, -32768};
`endif
    pulses = 0;
    first_seen = 0;
    for (int idx = 0; idx < IMG_W * IMG_H + 3; idx++) begin
      if (idx < IMG_W * IMG_H) step(1'b1, 1'b1, 8'd255);
      else step(1'b1, 1'b0, 8'd0);
      if (o_ready_feature !== exp_ready || o_feature_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL sat_ctrl cyc=%0d ready=%b valid=%b, want ready=%b valid=%b",
                 cyc, o_ready_feature, o_feature_valid, exp_ready, exp_valid);
      end
      vectors++;
      if (o_feature_valid === 1'b1) begin
        pulses++;
        bad = 0;
        for (int m = 0; m < NFM; m++) if (o_features[m] !== c255[m]) bad = 1;
        if (bad || !first_seen) begin
          if (bad) begin
            miscompares++;
            $display("FAIL sat_data cyc=%0d got %0d,%0d,%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d,%0d,%0d", cyc,
                     o_features[0], o_features[1], o_features[2], o_features[3], o_features[4], o_features[5],
                     c255[0], c255[1], c255[2], c255[3], c255[4], c255[5]);
          end
        end
        first_seen = 1;
        vectors++;
      end
    end
    if (pulses !== NWIN) begin
      miscompares++;
      $display("FAIL sat_count got %0d pulses want %0d", pulses, NWIN);
    end
    vectors++;
    $display("test_saturation: pulses %0d", pulses);
  endtask

  task automatic test_gaps();
    int pix, gap, drain, pulses;
    bit bad;
    pix = 0; drain = 0; pulses = 0;
    gap = $urandom_range(0, 3);
    while (pix < IMG_W * IMG_H || drain < 3) begin
      if (pix >= IMG_W * IMG_H) begin
        step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        drain++;
      end else if (gap > 0) begin
        step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        gap--;
      end else begin
        step(1'b1, 1'b1, 8'd40);
        pix++;
        gap = $urandom_range(0, 3);
      end
      if (o_ready_feature !== exp_ready || o_feature_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL gaps_ctrl cyc=%0d ready=%b valid=%b, want ready=%b valid=%b",
                 cyc, o_ready_feature, o_feature_valid, exp_ready, exp_valid);
      end
      vectors++;
      if (o_feature_valid === 1'b1) pulses++;
      bad = 0;
      for (int m = 0; m < NFM; m++) if (o_features[m] !== exp_feat[m]) bad = 1;
      if (bad) begin
        miscompares++;
        $display("FAIL gaps_data cyc=%0d got %0d,%0d,%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d,%0d,%0d", cyc,
                 o_features[0], o_features[1], o_features[2], o_features[3], o_features[4], o_features[5],
                 exp_feat[0], exp_feat[1], exp_feat[2], exp_feat[3], exp_feat[4], exp_feat[5]);
      end
      vectors++;
    end
    if (pulses !== NWIN) begin
      miscompares++;
      $display("FAIL gaps_count got %0d pulses want %0d", pulses, NWIN);
    end
    vectors++;
    $display("test_gaps: pulses %0d, ended at cycle %0d", pulses, cyc);
  endtask

  task automatic test_random_frame();
    int pix, pulses;
    bit bad;
    pix = 0; pulses = 0;
    while (pix < IMG_W * IMG_H + 3) begin
      if (pix < IMG_W * IMG_H && $urandom_range(0, 7) != 0) begin
        step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        pix++;
      end else begin
        step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        if (pix >= IMG_W * IMG_H) pix++;
      end
      if (o_ready_feature !== exp_ready || o_feature_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL rand_ctrl cyc=%0d ready=%b valid=%b, want ready=%b valid=%b",
                 cyc, o_ready_feature, o_feature_valid, exp_ready, exp_valid);
      end
      vectors++;
      if (o_feature_valid === 1'b1) pulses++;
      bad = 0;
      for (int m = 0; m < NFM; m++) if (o_features[m] !== exp_feat[m]) bad = 1;
      if (bad) begin
        miscompares++;
        $display("FAIL rand_data cyc=%0d got %0d,%0d,%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d,%0d,%0d", cyc,
                 o_features[0], o_features[1], o_features[2], o_features[3], o_features[4], o_features[5],
                 exp_feat[0], exp_feat[1], exp_feat[2], exp_feat[3], exp_feat[4], exp_feat[5]);
      end
      vectors++;
    end
    if (pulses !== NWIN) begin
      miscompares++;
      $display("FAIL rand_count got %0d pulses want %0d", pulses, NWIN);
    end
    vectors++;
    $display("test_random_frame: pulses %0d", pulses);
  endtask

  task automatic test_reset_mid();
    int n, pulses;
    bit bad;
    pulses = 0;
    // rows 0..10 partially, then one reset cycle, one idle cycle, a full frame, drain
    n = 10 * IMG_W + 7;
    for (int idx = 0; idx < n + 2 + IMG_W * IMG_H + 3; idx++) begin
      if (idx < n) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
      else if (idx == n) step(1'b0, 1'b1, 8'd40);
      else if (idx == n + 1) step(1'b1, 1'b0, 8'd40);
      else if (idx < n + 2 + IMG_W * IMG_H) step(1'b1, 1'b1, 8'd40);
      else step(1'b1, 1'b0, 8'd0);
      if (o_ready_feature !== exp_ready || o_feature_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL rstmid_ctrl cyc=%0d ready=%b valid=%b, want ready=%b valid=%b",
                 cyc, o_ready_feature, o_feature_valid, exp_ready, exp_valid);
      end
      vectors++;
      if (idx > n && o_feature_valid === 1'b1) pulses++;
      bad = 0;
      for (int m = 0; m < NFM; m++) if (o_features[m] !== exp_feat[m]) bad = 1;
      if (bad) begin
        miscompares++;
        $display("FAIL rstmid_data cyc=%0d got %0d,%0d,%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d,%0d,%0d", cyc,
                 o_features[0], o_features[1], o_features[2], o_features[3], o_features[4], o_features[5],
                 exp_feat[0], exp_feat[1], exp_feat[2], exp_feat[3], exp_feat[4], exp_feat[5]);
      end
      vectors++;
    end
    if (pulses !== NWIN) begin
      miscompares++;
      $display("FAIL rstmid_count got %0d pulses after reset want %0d", pulses, NWIN);
    end
    vectors++;
    $display("test_reset_mid: pulses after reset %0d", pulses);
  endtask

  initial begin
    i_rst = 1'b0;
    i_feature_valid = 1'b0;
    i_feature = 8'd0;
    m_row = 0;
    m_col = 0;
    m_ready = 1'b0;
    exp_valid = 1'b0;
    exp_ready = 1'b0;
    foreach (exp_feat[m]) exp_feat[m] = 0;
    #2;
    test_reset();
    test_const_frames();
    test_saturation();
    test_gaps();
    test_random_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
